hs32_fetch: RTL and testbench
=============================

// Module: hs32_fetch
// PURPOSE
//  Instruction fetch unit; the upstream end of the fetch->decode handshake.
//  Issues sequential 32-bit word reads to instruction memory and buffers the
//  returned words in a small FIFO. Presents them on instd/ackd to hs32_decode,
//  which pulls them with reqd. Execute can redirect the PC via flush/newpc.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; first fetch address
//  FIFO_DEPTH  2              instruction buffer entries; power of 2, >=2
// PORTS
//  clk       in   1   system clock (12 MHz)
//  reset_n   in   1   asynchronous active-low reset
//  mem_addr  out  32  instruction read address, word aligned
//  mem_req   out  1   read request; held with mem_addr stable until mem_ack
//  mem_ack   in   1   read complete; mem_data valid this cycle
//  mem_data  in   32  read data
//  instd     out  32  instruction at FIFO head
//  instpc    out  32  address of instd
//  ackd      out  1   instd/instpc valid (FIFO not empty)
//  reqd      in   1   decode takes the head word; transfer = reqd & ackd at posedge
//  flush     in   1   one-cycle redirect strobe from execute
//  newpc     in   32  redirect target, sampled when flush=1; bits[1:0] forced 0
// BEHAVIOUR
//  Reset (async on reset_n low): mem_req=0, mem_addr=RESET_PC, ackd=0,
//   instd=0, instpc=0, internal pc=RESET_PC, FIFO empty, FSM=IDLE.
//   reset_n low mid-transaction aborts it immediately; a late mem_ack is ignored.
//  All outputs registered. ackd = (count != 0). instd/instpc = FIFO head.
//  At most one memory read outstanding. FSM states: IDLE, BUSY, DISCARD.
//   IDLE: if !flush and count < FIFO_DEPTH -> mem_req<=1, mem_addr<=pc, BUSY.
//   BUSY: hold mem_req/mem_addr. On mem_ack:
//    - write {pc, mem_data} into FIFO; pc<=pc+4 (wraps 32'hFFFF_FFFC->0).
//    - if (count_next < FIFO_DEPTH), stay BUSY with mem_addr<=pc+4 and
//      mem_req=1 (back-to-back). count_next includes this push and any
//      same-cycle pop. Otherwise mem_req<=0 and go to IDLE.
//   DISCARD: hold mem_req until mem_ack; drop mem_data; then go to IDLE.
//  Flush (highest priority; wins over a same-cycle pop, push and issue):
//   - FIFO cleared, ackd<=0 next cycle, pc<=newpc&~3.
//   - IDLE: no issue this cycle; the next issue uses the new pc.
//   - BUSY without mem_ack: go to DISCARD.
//   - BUSY with mem_ack same cycle: data dropped, mem_req<=0, go to IDLE.
//   - DISCARD: stay in DISCARD; pc updated to the latest newpc.
//  Latency: first mem_req rises at the first posedge after reset release.
//   ackd rises the posedge after mem_ack is sampled. Zero-wait memory and
//   reqd held high sustain one instruction per cycle.
//  FIFO:
//   - Full: no issue. Overflow is impossible by the issue rule.
//   - Empty: reqd is ignored and pointers are unchanged.
//   - Simultaneous push and pop: count unchanged. If the FIFO was empty, the
//     pushed word still appears on the next cycle.
//   - Pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1 Reset release, memory acks 1 cycle after req returning 32'h0123_4567:
//    mem_addr=0, then ackd=1, instd=32'h0123_4567, instpc=0.
//  2 reqd held high, zero-wait memory: instpc sequence 0,4,8,C on consecutive
//    cycles with no bubbles.
//  3 reqd=0, memory always acks: exactly FIFO_DEPTH words buffered, then
//    mem_req=0. Raise reqd: the FIFO drains in order and fetch resumes at 8.
//  4 Flush newpc=32'h0000_0103 while BUSY with memory stalled: on the late ack
//    the data is discarded, the next mem_addr=32'h100, and ackd stays 0 until
//    the word at 0x100 returns.
//  5 Flush in the same cycle as mem_ack and reqd&ackd: FIFO empty next cycle,
//    the acked word never reaches instd, and the next fetch is newpc.
//  6 Assert reset_n low mid-BUSY, then ack while in reset: all outputs are at
//    reset values and the first fetch after release is RESET_PC.

Source files
------------

// File: rtl/hs32_fetch.sv
// hs32_fetch: sequential instruction fetch with a small prefetch FIFO.
// Feeds hs32_decode over instd/ackd/reqd and honours execute redirects via flush/newpc.
module hs32_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] instd,
    output logic [31:0] instpc,
    output logic        ackd,
    input  logic        reqd,
    input  logic        flush,
    input  logic [31:0] newpc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic               req_q, req_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        instd_q, instd_d;
    logic [31:0]        instpc_q, instpc_d;
    logic               ackd_q, ackd_d;

    logic [31:0]        fifo_data_q [FIFO_DEPTH];
    logic [31:0]        fifo_pc_q   [FIFO_DEPTH];

    logic               push, pop;
    logic [31:0]        pc_inc;
    logic [31:0]        newpc_aligned;

    // A flush cancels both the returning word and any pop in the same cycle.
    assign push          = (state_q == ST_BUSY) && mem_ack && !flush;
    assign pop           = reqd && (count_q != '0) && !flush;
    assign pc_inc        = pc_q + 32'd4;
    assign newpc_aligned = newpc & ~32'h0000_0003;

    // FIFO bookkeeping and the registered view of the next head entry.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        instd_d  = instd_q;
        instpc_d = instpc_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (count_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d)) begin
                    instd_d  = mem_data;
                    instpc_d = pc_q;
                end else begin
                    instd_d  = fifo_data_q[rd_ptr_d];
                    instpc_d = fifo_pc_q[rd_ptr_d];
                end
            end
        end
        ackd_d = (count_d != '0);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush && (count_q < DEPTH_C)) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (mem_ack) state_d = (!flush && (count_d < DEPTH_C)) ? ST_BUSY : ST_IDLE;
                else if (flush) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: request and address for the cycle after this edge.
    always_comb begin
        req_d  = (state_d != ST_IDLE);
        addr_d = addr_q;
        if ((state_q == ST_IDLE) && (state_d == ST_BUSY)) addr_d = pc_q;
        else if ((state_q == ST_BUSY) && (state_d == ST_BUSY) && mem_ack) addr_d = pc_inc;
    end

    always_comb begin
        pc_d = pc_q;
        if (flush)     pc_d = newpc_aligned;
        else if (push) pc_d = pc_inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instd_q  <= '0;
            instpc_q <= '0;
            ackd_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instd_q  <= instd_d;
            instpc_q <= instpc_d;
            ackd_q   <= ackd_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only read after being written, tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_data;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

    assign mem_addr = addr_q;
    assign mem_req  = req_q;
    assign instd    = instd_q;
    assign instpc   = instpc_q;
    assign ackd     = ackd_q;

endmodule

// File: tb/tb_hs32_fetch.sv
// Directed bench for hs32_fetch: a memory model, a scoreboard of expected words,
// and a monitor that checks every decode transfer against that scoreboard.
module tb_hs32_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_ack_m;
    logic        mem_ack_f;
    logic [31:0] mem_data;
    logic [31:0] instd;
    logic [31:0] instpc;
    logic        ackd;
    logic        reqd;
    logic        flush;
    logic [31:0] newpc;

    int          mem_wait;
    logic        mem_stall;
    int          wait_cnt;

    int          vectors     = 0;
    int          miscompares = 0;
    int          xfer_cnt    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    assign mem_ack = mem_ack_m | mem_ack_f;

    hs32_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mem_addr(mem_addr),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .mem_data(mem_data),
        .instd   (instd),
        .instpc  (instpc),
        .ackd    (ackd),
        .reqd    (reqd),
        .flush   (flush),
        .newpc   (newpc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0001) ^ 32'h0123_4567;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Memory: answers mem_wait cycles after a request is seen, unless stalled.
    always @(posedge clk) begin
        #2;
        if (mem_req && reset_n && !mem_stall) begin
            if (wait_cnt >= mem_wait) begin
                mem_ack_m = 1'b1;
                mem_data  = mem_word(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack_m = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack_m = 1'b0;
            if (!mem_req) wait_cnt = 0;
        end
    end

    // Monitor: a transfer happens at the next posedge when reqd & ackd and no flush.
    always @(negedge clk) begin
        if (reset_n && ackd && reqd && !flush) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_extra: unexpected word pc=%h data=%h, expected none", instpc, instd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", instpc, e.pc);
                check("sb_data", instd, e.data);
            end
            xfer_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] data);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic start_reset();
        reset_n   = 1'b0;
        reqd      = 1'b0;
        flush     = 1'b0;
        newpc     = '0;
        mem_stall = 1'b0;
        mem_ack_f = 1'b0;
        mem_wait  = 0;
        exp_q.delete();
        tick(2);
        xfer_cnt  = 0;
    endtask

    task automatic wait_xfer(input string name, input int target);
        for (int i = 0; i < 60 && xfer_cnt < target; i++) tick(1);
        check(name, 32'(xfer_cnt), 32'(target));
    endtask

    task automatic wait_ackd(input string name);
        for (int i = 0; i < 30 && !ackd; i++) tick(1);
        check(name, {31'b0, ackd}, 32'd1);
    endtask

    initial begin
        logic [31:0] first_addr;
        logic        saw_drop;
        logic        got_addr;

        mem_ack_m = 1'b0;
        mem_data  = '0;
        wait_cnt  = 0;

        // 1: reset state, first fetch and one-cycle memory latency
        start_reset();
        check("t1_rst_req", {31'b0, mem_req}, 32'd0);
        check("t1_rst_addr", mem_addr, 32'h0);
        check("t1_rst_ackd", {31'b0, ackd}, 32'd0);
        check("t1_rst_instd", instd, 32'h0);
        check("t1_rst_instpc", instpc, 32'h0);
        mem_wait = 1;
        reset_n  = 1'b1;
        tick(1);
        check("t1_first_req", {31'b0, mem_req}, 32'd1);
        check("t1_first_addr", mem_addr, 32'h0);
        check("t1_ackd_early", {31'b0, ackd}, 32'd0);
        wait_ackd("t1_ackd");
        check("t1_instd", instd, 32'h0123_4567);
        check("t1_instpc", instpc, 32'h0);
        expect_word(32'h0, 32'h0123_4567);
        expect_word(32'h4, 32'h0127_4563);
        reqd = 1'b1;
        wait_xfer("t1_xfers", 2);
        reqd = 1'b0;
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: zero-wait memory with reqd high streams one word per cycle
        start_reset();
        reqd = 1'b1;
        expect_word(32'h0, 32'h0123_4567);
        expect_word(32'h4, 32'h0127_4563);
        expect_word(32'h8, 32'h012B_456F);
        expect_word(32'hC, 32'h012F_456B);
        reset_n = 1'b1;
        wait_ackd("t2_ackd");
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check("t2_no_bubble", {31'b0, ackd}, 32'd1);
        end
        wait_xfer("t2_xfers", 4);
        reqd = 1'b0;
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: FIFO fills to depth and stops fetching, then drains and resumes at 8
        start_reset();
        reset_n = 1'b1;
        tick(8);
        check("t3_full_req", {31'b0, mem_req}, 32'd0);
        check("t3_full_addr", mem_addr, 32'h4);
        check("t3_full_ackd", {31'b0, ackd}, 32'd1);
        check("t3_full_head", instpc, 32'h0);
        expect_word(32'h0, 32'h0123_4567);
        expect_word(32'h4, 32'h0127_4563);
        expect_word(32'h8, 32'h012B_456F);
        reqd = 1'b1;
        wait_xfer("t3_xfers", 3);
        reqd = 1'b0;
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: flush while BUSY with a stalled memory; the late word is dropped
        start_reset();
        mem_stall = 1'b1;
        reset_n   = 1'b1;
        tick(2);
        flush = 1'b1;
        newpc = 32'h0000_0103;
        tick(1);
        flush = 1'b0;
        check("t4_discard_req", {31'b0, mem_req}, 32'd1);
        check("t4_discard_addr", mem_addr, 32'h0);
        check("t4_discard_ackd", {31'b0, ackd}, 32'd0);
        mem_stall  = 1'b0;
        saw_drop   = 1'b0;
        got_addr   = 1'b0;
        first_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && !ackd; i++) begin
            tick(1);
            if (!mem_req) saw_drop = 1'b1;
            else if (saw_drop && !got_addr) begin
                got_addr   = 1'b1;
                first_addr = mem_addr;
            end
        end
        check("t4_next_addr", first_addr, 32'h0000_0100);
        check("t4_first_ackd", {31'b0, ackd}, 32'd1);
        check("t4_first_instpc", instpc, 32'h0000_0100);
        check("t4_first_instd", instd, 32'h0023_4467);

        // 5: flush coincides with mem_ack and a pending transfer
        start_reset();
        mem_wait = 1;
        reset_n  = 1'b1;
        for (int i = 0; i < 20 && !(mem_ack && ackd && mem_addr == 32'h4); i++) tick(1);
        check("t5_setup_ack", {31'b0, mem_ack}, 32'd1);
        flush = 1'b1;
        newpc = 32'h0000_0200;
        reqd  = 1'b1;
        expect_word(32'h0000_0200, 32'h0323_4767);
        tick(1);
        flush = 1'b0;
        check("t5_empty_ackd", {31'b0, ackd}, 32'd0);
        check("t5_req_drop", {31'b0, mem_req}, 32'd0);
        tick(1);
        check("t5_refetch_req", {31'b0, mem_req}, 32'd1);
        check("t5_refetch_addr", mem_addr, 32'h0000_0200);
        wait_xfer("t5_xfers", 1);
        reqd = 1'b0;
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset mid-transaction, with a stray ack while reset is held
        start_reset();
        mem_wait = 1;
        reset_n  = 1'b1;
        wait_ackd("t6_ackd");
        mem_stall = 1'b1;
        tick(1);
        check("t6_busy_addr", mem_addr, 32'h4);
        reset_n = 1'b0;
        #1;
        check("t6_rst_req", {31'b0, mem_req}, 32'd0);
        check("t6_rst_addr", mem_addr, 32'h0);
        check("t6_rst_ackd", {31'b0, ackd}, 32'd0);
        check("t6_rst_instd", instd, 32'h0);
        check("t6_rst_instpc", instpc, 32'h0);
        mem_ack_f = 1'b1;
        tick(1);
        mem_ack_f = 1'b0;
        mem_stall = 1'b0;
        check("t6_hold_ackd", {31'b0, ackd}, 32'd0);
        check("t6_hold_req", {31'b0, mem_req}, 32'd0);
        reset_n = 1'b1;
        tick(1);
        check("t6_restart_req", {31'b0, mem_req}, 32'd1);
        check("t6_restart_addr", mem_addr, 32'h0);
        wait_ackd("t6_restart_ackd");
        check("t6_restart_instpc", instpc, 32'h0);

        // 7: flush in IDLE suppresses the issue; pc wraps past the top of memory
        start_reset();
        flush   = 1'b1;
        newpc   = 32'hFFFF_FFFE;
        reqd    = 1'b1;
        expect_word(32'hFFFF_FFFC, 32'hFED8_BA9B);
        expect_word(32'h0000_0000, 32'h0123_4567);
        reset_n = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t7_no_issue", {31'b0, mem_req}, 32'd0);
        tick(1);
        check("t7_issue_req", {31'b0, mem_req}, 32'd1);
        check("t7_issue_addr", mem_addr, 32'hFFFF_FFFC);
        wait_xfer("t7_xfers", 2);
        reqd = 1'b0;
        check("t7_sb_empty", 32'(exp_q.size()), 32'd0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
